// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receive front end: 11-bit frames in, scan code + valid/released out.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       key_released,
  output logic       frame_err
);

  localparam int             CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1, clk_s2, clk_hist;
  logic          dat_s1, dat_s2;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          break_pending;
  logic [CW-1:0] to_cnt;
  logic          fall;
  logic          parity_ok;
  logic          timed_out;

  assign fall      = clk_hist & ~clk_s2;
  assign timed_out = (state != IDLE) && !fall && (to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  assign parity_ok = ^{shreg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: synchronizer and edge history reset to the idle-high line level,
      // so leaving reset can never look like a falling edge.
      clk_s1        <= 1'b1;
      clk_s2        <= 1'b1;
      clk_hist      <= 1'b1;
      dat_s1        <= 1'b1;
      dat_s2        <= 1'b1;
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      break_pending <= 1'b0;
      to_cnt        <= '0;
      data          <= 8'h00;
      data_valid    <= 1'b0;
      key_released  <= 1'b0;
      frame_err     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments everywhere here, so the sync chain
      // advances exactly one stage per clock regardless of statement order.
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_hist   <= clk_s2;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      // Inter-edge watchdog: only runs while a frame is in progress
      if (state == IDLE || fall || timed_out) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 1'b1;

      if (timed_out) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg <= {dat_s2, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= dat_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && parity_ok) begin
              if (shreg == 8'hF0) begin
                break_pending <= 1'b1;
              end else begin
                data          <= shreg;
                key_released  <= break_pending;
                break_pending <= 1'b0;
                data_valid    <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
